wb_regfile: RTL and testbench

- Writeback stage of the pipelined Y86-64 core; consumes the W pipeline register fields.
- Decodes the write destinations (dstE, dstM) from icode, rA, rB and cnd, and holds the 15-entry 64-bit program register file.
- Serves two combinational read ports to the decode stage.
- Tracks the processor status: sticky halt/exception, plus a retired-instruction counter.

---
 rtl/y86_pkg.sv | 33 +++
 rtl/wb_dst_decode.sv | 32 +++
 rtl/wb_regfile.sv | 95 +++++++++
 tb/tb_wb_regfile.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, status codes and register ids.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SBUB = 3'd0;
  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  localparam int unsigned NREGS = 15;

  // Statuses that stop the machine once they retire.
  function automatic logic is_fault(input logic [2:0] stat);
    return (stat == SHLT) || (stat == SADR) || (stat == SINS);
  endfunction

endpackage

// File: rtl/wb_dst_decode.sv
// Combinational writeback destination decode (dstE / dstM) from W-stage fields.
module wb_dst_decode
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ra,
  input  logic [3:0] rb,
  input  logic       cnd,
  output logic [3:0] dst_e,
  output logic [3:0] dst_m
);

  always_comb begin
    dst_e = RNONE;
    case (icode)
      IRRMOVQ:                     dst_e = cnd ? rb : RNONE;
      IIRMOVQ, IOPQ:               dst_e = rb;
      ICALL, IRET, IPUSHQ, IPOPQ:  dst_e = RRSP;
      IHALT, INOP, IRMMOVQ, IJXX:  dst_e = RNONE;
      default:                     dst_e = RNONE;
    endcase
  end

  always_comb begin
    dst_m = RNONE;
    case (icode)
      IMRMOVQ, IPOPQ: dst_m = ra;
      default:        dst_m = RNONE;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// Y86-64 writeback stage: program register file, sticky fault status and
// retired-instruction counter.
module wb_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_RESET = 64'h0,
  parameter int unsigned CNT_W     = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       w_stat,
  input  logic [3:0]       w_icode,
  input  logic [3:0]       w_rA,
  input  logic [3:0]       w_rB,
  input  logic             w_cnd,
  input  logic [63:0]      w_valE,
  input  logic [63:0]      w_valM,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  output logic [63:0]      d_rvalA,
  output logic [63:0]      d_rvalB,
  output logic [3:0]       w_dstE,
  output logic [3:0]       w_dstM,
  output logic [2:0]       cpu_stat,
  output logic             halted,
  output logic [CNT_W-1:0] instret
);

  logic [63:0]      regs [NREGS];
  logic             halted_q;
  logic [2:0]       fault_q;
  logic [CNT_W-1:0] instret_q;
  logic             wen;

  wb_dst_decode u_dst_decode (
    .icode (w_icode),
    .ra    (w_rA),
    .rb    (w_rB),
    .cnd   (w_cnd),
    .dst_e (w_dstE),
    .dst_m (w_dstM)
  );

  assign wen = !halted_q && (w_stat == SAOK);

  // No write-through: decode forwarding covers same-cycle writes.
  assign d_rvalA = (d_srcA == RNONE) ? 64'h0 : regs[d_srcA];
  assign d_rvalB = (d_srcB == RNONE) ? 64'h0 : regs[d_srcB];

  // valM takes priority over valE when both target the same register (popq %rsp).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (i == int'(RRSP)) ? RSP_RESET : 64'h0;
      end
    end else if (wen) begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_dstM == 4'(i)) begin
          regs[i] <= w_valM;
        end else if (w_dstE == 4'(i)) begin
          regs[i] <= w_valE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halted_q  <= 1'b0;
      fault_q   <= SAOK;
      instret_q <= '0;
    end else begin
      if (!halted_q && is_fault(w_stat)) begin
        halted_q <= 1'b1;
        fault_q  <= w_stat;
      end
      if (wen) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    cpu_stat = w_stat;
    if (halted_q) begin
      cpu_stat = fault_q;
    end else if (w_stat == SBUB) begin
      cpu_stat = SAOK;
    end
  end

  assign halted  = halted_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed vector table, reset corner
// cases and a randomized run against an architectural reference model.
module tb_wb_regfile;

  localparam logic [63:0] RSP_INIT = 64'h0000_0000_0000_F000;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  w_stat;
  logic [3:0]  w_icode, w_rA, w_rB;
  logic        w_cnd;
  logic [63:0] w_valE, w_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [63:0] d_rvalA, d_rvalB;
  logic [3:0]  w_dstE, w_dstM;
  logic [2:0]  cpu_stat;
  logic        halted;
  logic [63:0] instret;

  int checks = 0;
  int errors = 0;

  // Architectural model state
  logic [63:0] m_reg [15];
  logic        m_halted;
  logic [2:0]  m_fstat;
  logic [63:0] m_instret;

  wb_regfile #(
    .RSP_RESET (RSP_INIT),
    .CNT_W     (64)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .w_stat   (w_stat),
    .w_icode  (w_icode),
    .w_rA     (w_rA),
    .w_rB     (w_rB),
    .w_cnd    (w_cnd),
    .w_valE   (w_valE),
    .w_valM   (w_valM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .d_rvalA  (d_rvalA),
    .d_rvalB  (d_rvalB),
    .w_dstE   (w_dstE),
    .w_dstM   (w_dstM),
    .cpu_stat (cpu_stat),
    .halted   (halted),
    .instret  (instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] m_dste(input logic [3:0] ic, input logic [3:0] rb,
                                        input logic cnd);
    if (ic == 4'h2) return cnd ? rb : 4'hF;
    if (ic == 4'h3 || ic == 4'h6) return rb;
    if (ic >= 4'h8 && ic <= 4'hB) return 4'h4;
    return 4'hF;
  endfunction

  function automatic logic [3:0] m_dstm(input logic [3:0] ic, input logic [3:0] ra);
    return (ic == 4'h5 || ic == 4'hB) ? ra : 4'hF;
  endfunction

  function automatic logic [63:0] m_read(input logic [3:0] a);
    return (a == 4'hF) ? 64'h0 : m_reg[a];
  endfunction

  function automatic logic [2:0] m_cpu();
    if (m_halted) return m_fstat;
    return (w_stat == 3'd0) ? 3'd1 : w_stat;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = (i == 4) ? RSP_INIT : 64'h0;
    m_halted  = 1'b0;
    m_fstat   = 3'd1;
    m_instret = 64'h0;
  endtask

  // Commit the current W inputs to the model, then advance the DUT one edge.
  task automatic tick();
    logic [3:0] de, dm;
    de = m_dste(w_icode, w_rB, w_cnd);
    dm = m_dstm(w_icode, w_rA);
    if (!m_halted && w_stat == 3'd1) begin
      if (de != 4'hF) m_reg[de] = w_valE;
      if (dm != 4'hF) m_reg[dm] = w_valM;
      m_instret = m_instret + 64'd1;
    end
    if (!m_halted && (w_stat == 3'd2 || w_stat == 3'd3 || w_stat == 3'd4)) begin
      m_halted = 1'b1;
      m_fstat  = w_stat;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bubble();
    w_stat = 3'd0; w_icode = 4'h1; w_rA = 4'hF; w_rB = 4'hF; w_cnd = 1'b0;
    w_valE = 64'h0; w_valM = 64'h0;
  endtask

  task automatic apply_reset();
    drive_bubble();
    rst = 1'b1;
    #3;
    rst = 1'b0;
    model_reset();
    #1;
  endtask

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ra, rb;
    logic        cnd;
    logic [63:0] vale, valm;
    logic [3:0]  chk;
    logic [63:0] exp_reg;
    logic [3:0]  exp_dste, exp_dstm;
    logic [2:0]  exp_cpu;
    logic        exp_halt;
    logic [63:0] exp_ret;
  } vec_t;

  vec_t vt [11];

  initial begin
    rst = 1'b0;
    d_srcA = 4'hF; d_srcB = 4'hF;
    drive_bubble();
    @(posedge clk);
    #1;
    apply_reset();

    // Reset contents through both read ports
    for (int i = 0; i < 15; i++) begin
      d_srcA = 4'(i);
      d_srcB = 4'(14 - i);
      #1;
      check($sformatf("reset_rA[%0d]", i), d_rvalA, (i == 4) ? RSP_INIT : 64'h0);
      check($sformatf("reset_rB[%0d]", 14 - i), d_rvalB, (14 - i == 4) ? RSP_INIT : 64'h0);
    end
    d_srcA = 4'hF; d_srcB = 4'hF;
    #1;
    check("srcA_none", d_rvalA, 64'h0);
    check("reset_cpu_stat", 64'(cpu_stat), 64'd1);
    check("reset_halted", 64'(halted), 64'd0);
    check("reset_instret", instret, 64'd0);

    //          stat  icode rA    rB    cnd   valE          valM        chk   exp_reg     dE    dM    cpu   hlt   ret
    vt[0]  = '{3'd1, 4'h3, 4'hF, 4'h3, 1'b0, 64'h1234,     64'h0,      4'h3, 64'h1234,   4'h3, 4'hF, 3'd1, 1'b0, 64'd1};
    vt[1]  = '{3'd1, 4'h2, 4'hF, 4'h5, 1'b0, 64'hFF,       64'h0,      4'h5, 64'h0,      4'hF, 4'hF, 3'd1, 1'b0, 64'd2};
    vt[2]  = '{3'd1, 4'h2, 4'hF, 4'h5, 1'b1, 64'hFF,       64'h0,      4'h5, 64'hFF,     4'h5, 4'hF, 3'd1, 1'b0, 64'd3};
    vt[3]  = '{3'd1, 4'h6, 4'h1, 4'h6, 1'b0, 64'h77,       64'h0,      4'h6, 64'h77,     4'h6, 4'hF, 3'd1, 1'b0, 64'd4};
    vt[4]  = '{3'd1, 4'h5, 4'h7, 4'h2, 1'b0, 64'h99,       64'hABCD,   4'h7, 64'hABCD,   4'hF, 4'h7, 3'd1, 1'b0, 64'd5};
    vt[5]  = '{3'd1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h100,      64'hBEEF,   4'h4, 64'hBEEF,   4'h4, 4'h4, 3'd1, 1'b0, 64'd6};
    vt[6]  = '{3'd1, 4'hA, 4'h8, 4'hF, 1'b0, 64'h200,      64'h55,     4'h4, 64'h200,    4'h4, 4'hF, 3'd1, 1'b0, 64'd7};
    vt[7]  = '{3'd0, 4'h1, 4'hF, 4'hF, 1'b0, 64'h0,        64'h0,      4'h4, 64'h200,    4'hF, 4'hF, 3'd1, 1'b0, 64'd7};
    vt[8]  = '{3'd0, 4'h3, 4'hF, 4'h1, 1'b0, 64'h5,        64'h0,      4'h1, 64'h0,      4'h1, 4'hF, 3'd1, 1'b0, 64'd7};
    vt[9]  = '{3'd3, 4'h3, 4'hF, 4'h2, 1'b0, 64'h7,        64'h0,      4'h2, 64'h0,      4'h2, 4'hF, 3'd3, 1'b1, 64'd7};
    vt[10] = '{3'd1, 4'h3, 4'hF, 4'h3, 1'b0, 64'h5555,     64'h0,      4'h3, 64'h1234,   4'h3, 4'hF, 3'd3, 1'b1, 64'd7};

    for (int v = 0; v < 11; v++) begin
      w_stat = vt[v].stat; w_icode = vt[v].icode; w_rA = vt[v].ra; w_rB = vt[v].rb;
      w_cnd = vt[v].cnd; w_valE = vt[v].vale; w_valM = vt[v].valm;
      #1;
      check($sformatf("vec%0d_dstE", v), 64'(w_dstE), 64'(vt[v].exp_dste));
      check($sformatf("vec%0d_dstM", v), 64'(w_dstM), 64'(vt[v].exp_dstm));
      check($sformatf("vec%0d_cpu_stat", v), 64'(cpu_stat), 64'(vt[v].exp_cpu));
      tick();
      drive_bubble();
      d_srcA = vt[v].chk;
      #1;
      check($sformatf("vec%0d_reg%0h", v, vt[v].chk), d_rvalA, vt[v].exp_reg);
      check($sformatf("vec%0d_halted", v), 64'(halted), 64'(vt[v].exp_halt));
      check($sformatf("vec%0d_instret", v), instret, vt[v].exp_ret);
    end
    check("halted_cpu_stat_bubble", 64'(cpu_stat), 64'd3);

    // Asynchronous reset mid-cycle, held over an edge carrying an AOK write
    w_stat = 3'd1; w_icode = 4'h3; w_rA = 4'hF; w_rB = 4'h3; w_cnd = 1'b0;
    w_valE = 64'hDEAD; w_valM = 64'h0;
    d_srcA = 4'h3; d_srcB = 4'h4;
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_halted", 64'(halted), 64'd0);
    check("async_rst_instret", instret, 64'd0);
    check("async_rst_cpu_stat", 64'(cpu_stat), 64'd1);
    check("async_rst_reg3", d_rvalA, 64'h0);
    check("async_rst_rsp", d_rvalB, RSP_INIT);
    @(posedge clk);
    #1;
    check("rst_edge_reg3", d_rvalA, 64'h0);
    check("rst_edge_instret", instret, 64'd0);
    rst = 1'b0;
    model_reset();
    drive_bubble();
    #1;

    // Randomized run against the model
    for (int c = 0; c < 600; c++) begin
      int unsigned sel;
      if (c % 75 == 74) apply_reset();
      sel = $urandom_range(0, 99);
      if (sel < 4)       w_stat = 3'($urandom_range(2, 4));
      else if (sel < 16) w_stat = 3'd0;
      else if (sel < 19) w_stat = 3'($urandom_range(5, 7));
      else               w_stat = 3'd1;
      w_icode = 4'($urandom_range(0, 15));
      w_rA    = 4'($urandom_range(0, 15));
      w_rB    = 4'($urandom_range(0, 15));
      w_cnd   = 1'($urandom_range(0, 1));
      w_valE  = {$urandom, $urandom};
      w_valM  = {$urandom, $urandom};
      d_srcA  = 4'($urandom_range(0, 15));
      d_srcB  = 4'($urandom_range(0, 15));
      #1;
      check($sformatf("rnd%0d_rvalA", c), d_rvalA, m_read(d_srcA));
      check($sformatf("rnd%0d_rvalB", c), d_rvalB, m_read(d_srcB));
      check($sformatf("rnd%0d_dstE", c), 64'(w_dstE), 64'(m_dste(w_icode, w_rB, w_cnd)));
      check($sformatf("rnd%0d_dstM", c), 64'(w_dstM), 64'(m_dstm(w_icode, w_rA)));
      check($sformatf("rnd%0d_cpu_stat", c), 64'(cpu_stat), 64'(m_cpu()));
      check($sformatf("rnd%0d_halted", c), 64'(halted), 64'(m_halted));
      check($sformatf("rnd%0d_instret", c), instret, m_instret);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
